// File: rtl/tt_param_updown_counter.sv
// rtl/tt_param_updown_counter.sv - parametrised up/down counter with prescaler, load, wrap/saturate, tc and sticky ovf
//
// Purpose:
//   Counts within 0..MODULO-1. Each count step needs PRESCALE enabled cycles.
//   The counter either wraps or saturates at the range ends. Wrapping emits a
//   one-cycle terminal-count pulse. Hitting a range end in either mode sets a
//   sticky overflow flag.
//
// Ports:
//   clk       in   1      clock; all state changes on posedge
//   rst_n     in   1      asynchronous active-low reset
//   enable    in   1      advances the prescaler; count steps only while high
//   up_dn     in   1      1 = up, 0 = down (sampled on step cycles)
//   sat_mode  in   1      1 = saturate, 0 = wrap (sampled on step cycles)
//   load      in   1      synchronous load strobe (beats enable)
//   load_val  in   WIDTH  load value, clamped to MODULO-1
//   clr_ovf   in   1      clears ovf unless ovf is being set in the same cycle
//   count     out  WIDTH  registered count
//   tc        out  1      registered one-cycle wrap pulse
//   ovf       out  1      sticky range-end flag

module tt_param_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MODULO    = 256,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // The prescaler is at least one bit wide so that PRESCALE=1 still has a legal register.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             ovf_set;
  logic [WIDTH-1:0] load_clamped;

  assign step         = enable && (pre_q == PRE_LAST);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;

    if (load) begin
      count_d = load_clamped;
      pre_d   = '0;
    end else begin
      // When enable is low the prescaler holds, so the phase is kept.
      if (enable) begin
        pre_d = step ? '0 : pre_q + PW'(1);
      end

      if (step) begin
        if (up_dn) begin
          if (count_q == MAX_VAL) begin
            ovf_set = 1'b1;
            if (!sat_mode) begin
              count_d = '0;
              tc_d    = 1'b1;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            ovf_set = 1'b1;
            if (!sat_mode) begin
              count_d = MAX_VAL;
              tc_d    = 1'b1;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end

    // A set in the same cycle wins over the clear.
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_COUNT;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_tt_param_updown_counter.sv
// tb/tb_tt_param_updown_counter.sv - directed self-checking bench for tt_param_updown_counter

module tb_tt_param_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       up_dn;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;

  logic [3:0] count;
  logic       tc;
  logic       ovf;
  logic [3:0] count_p;
  logic       tc_p;
  logic       ovf_p;

  int tests_run;
  int tests_failed;

  tt_param_updown_counter #(
    .WIDTH(4), .MODULO(10), .PRESCALE(1), .RESET_VAL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count), .tc(tc), .ovf(ovf)
  );

  tt_param_updown_counter #(
    .WIDTH(4), .MODULO(10), .PRESCALE(3), .RESET_VAL(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count_p), .tc(tc_p), .ovf(ovf_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable   = 1'b0;
    up_dn    = 1'b1;
    sat_mode = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    clr_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [3:0] v, input logic clr);
    load     = 1'b1;
    load_val = v;
    clr_ovf  = clr;
    tick();
    load     = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_initial: count=%0d tc=%b ovf=%b, required 0 0 0", count, tc, ovf);
    end
    tick();
    rst_n = 1'b1;
    // Reach count=5 with ovf set: load 4, up-wrap 1 step to 5? No: use 9 -> wrap -> then 5 steps.
    do_load(4'd9, 1'b0);
    up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    repeat (6) tick();
    enable = 1'b0;
    tests_run++;
    if (count !== 4'd5 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_setup: count=%0d ovf=%b, required 5 1", count, ovf);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: count=%0d tc=%b ovf=%b, required 0 0 0", count, tc, ovf);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_c;
    idle_inputs();
    do_reset();
    up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_c = 4'(i % 10);
      tests_run++;
      if (count !== exp_c || tc !== (i == 10) || ovf !== (i >= 10)) begin
        tests_failed++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b ovf=%b, required %0d %b %b",
                 i, count, tc, ovf, exp_c, (i == 10), (i >= 10));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_sat_down();
    logic [3:0] exp_c;
    idle_inputs();
    do_load(4'd2, 1'b1);
    tests_run++;
    if (count !== 4'd2 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_down_load: count=%0d ovf=%b, required 2 0", count, ovf);
    end
    up_dn = 1'b0; sat_mode = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_c = (k == 1) ? 4'd1 : 4'd0;
      tests_run++;
      if (count !== exp_c || tc !== 1'b0 || ovf !== (k >= 3)) begin
        tests_failed++;
        $display("FAIL sat_down[%0d]: count=%0d tc=%b ovf=%b, required %0d 0 %b",
                 k, count, tc, ovf, exp_c, (k >= 3));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_sat_up();
    idle_inputs();
    do_load(4'd9, 1'b1);
    up_dn = 1'b1; sat_mode = 1'b1; enable = 1'b1;
    tick();
    enable = 1'b0;
    tests_run++;
    if (count !== 4'd9 || tc !== 1'b0 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_up: count=%0d tc=%b ovf=%b, required 9 0 1", count, tc, ovf);
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp_c;
    idle_inputs();
    do_reset();
    up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_c = 4'(k / 3);
      tests_run++;
      if (count_p !== exp_c || tc_p !== 1'b0) begin
        tests_failed++;
        $display("FAIL prescale[%0d]: count=%0d tc=%b, required %0d 0", k, count_p, tc_p, exp_c);
      end
    end
    // One enabled cycle, two disabled, then two enabled: step lands on the last.
    tick();
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    tests_run++;
    if (count_p !== 4'd3) begin
      tests_failed++;
      $display("FAIL prescale_gap_early: count=%0d, required 3", count_p);
    end
    tick();
    tests_run++;
    if (count_p !== 4'd4) begin
      tests_failed++;
      $display("FAIL prescale_gap_step: count=%0d, required 4", count_p);
    end
    enable = 1'b0;
  endtask

  task automatic test_load_clamp();
    idle_inputs();
    up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    tick();                         // dut_p prescaler now mid-phase
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    tests_run++;
    if (count !== 4'd9 || tc !== 1'b0 || count_p !== 4'd9 || tc_p !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_clamp: count=%0d tc=%b count_p=%0d tc_p=%b, required 9 0 9 0",
               count, tc, count_p, tc_p);
    end
    tick();
    tests_run++;
    if (count !== 4'd0 || tc !== 1'b1 || count_p !== 4'd9) begin
      tests_failed++;
      $display("FAIL load_phase1: count=%0d tc=%b count_p=%0d, required 0 1 9", count, tc, count_p);
    end
    tick();
    tests_run++;
    if (count_p !== 4'd9 || tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_phase2: count_p=%0d tc=%b, required 9 0", count_p, tc);
    end
    tick();
    tests_run++;
    if (count_p !== 4'd0 || tc_p !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_phase3: count_p=%0d tc_p=%b, required 0 1", count_p, tc_p);
    end
    enable = 1'b0;
  endtask

  task automatic test_ovf_clear();
    idle_inputs();
    do_load(4'd9, 1'b1);
    tests_run++;
    if (ovf !== 1'b0 || count !== 4'd9) begin
      tests_failed++;
      $display("FAIL ovf_pre: count=%0d ovf=%b, required 9 0", count, ovf);
    end
    up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1; clr_ovf = 1'b1;
    tick();
    tests_run++;
    if (count !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set_wins: count=%0d tc=%b ovf=%b, required 0 1 1", count, tc, ovf);
    end
    enable = 1'b0;
    tick();
    clr_ovf = 1'b0;
    tests_run++;
    if (ovf !== 1'b0 || tc !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL ovf_clear: count=%0d tc=%b ovf=%b, required 0 0 0", count, tc, ovf);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    do_load(4'd0, 1'b1);
    up_dn = 1'b0; sat_mode = 1'b0; enable = 1'b1;
    tick();
    tests_run++;
    if (count !== 4'd9 || tc !== 1'b1 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL down_wrap: count=%0d tc=%b ovf=%b, required 9 1 1", count, tc, ovf);
    end
    tick();
    tests_run++;
    if (count !== 4'd8 || tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_after_wrap: count=%0d tc=%b, required 8 0", count, tc);
    end
    up_dn = 1'b1;
    tick();
    tests_run++;
    if (count !== 4'd9 || tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL dir_change: count=%0d tc=%b, required 9 0", count, tc);
    end
    enable = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_sat_up();
    test_prescale();
    test_load_clamp();
    test_ovf_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
